// File: rtl/axis_pl_to_ps.sv
// Width-down converter: splits each wide ADC-side word into R PS-side beats,
// least-significant slice first, and marks every FRAME_BEATS-th beat with tlast.
module axis_pl_to_ps #(
    parameter int IN_WIDTH    = 128,
    parameter int OUT_WIDTH   = 32,
    parameter int FRAME_BEATS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast
);

    localparam int R  = IN_WIDTH / OUT_WIDTH;
    localparam int SW = $clog2(R);
    localparam int CW = $clog2(FRAME_BEATS) + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                state_q;
    logic [SW-1:0]         slice_q;
    logic [CW-1:0]         beat_q;
    logic [IN_WIDTH-1:0]   hold_q;
    logic [OUT_WIDTH-1:0]  slices [R];

    logic last_slice;
    logic last_beat;
    logic in_hs;
    logic out_hs;

    assign last_slice = (slice_q == SW'(R - 1));
    assign last_beat  = (beat_q == CW'(FRAME_BEATS - 1));

    // A new word may enter on the same edge the final slice leaves, so a
    // streaming source sees no bubble; rst gates ready to 0 while asserted.
    assign s_axis_tready = !rst && !clear &&
                           ((state_q == EMPTY) || (last_slice && m_axis_tready));

    assign in_hs  = s_axis_tvalid && s_axis_tready;
    assign out_hs = (state_q == FULL) && m_axis_tready;

    always_comb begin
        for (int i = 0; i < R; i++) begin
            slices[i] = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    assign m_axis_tdata  = slices[slice_q];
    assign m_axis_tvalid = (state_q == FULL);
    assign m_axis_tlast  = (state_q == FULL) && last_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            slice_q <= '0;
            beat_q  <= '0;
            hold_q  <= '0;
        end else if (clear) begin
            state_q <= EMPTY;
            slice_q <= '0;
            beat_q  <= '0;
        end else begin
            if (out_hs) begin
                beat_q  <= last_beat ? '0 : beat_q + CW'(1);
                slice_q <= slice_q + SW'(1);
                if (last_slice) begin
                    state_q <= EMPTY;
                    slice_q <= '0;
                end
            end
            // Acceptance overrides the drain-to-EMPTY of the final slice.
            if (in_hs) begin
                hold_q  <= s_axis_tdata;
                slice_q <= '0;
                state_q <= FULL;
            end
        end
    end

endmodule

// File: doc/axis_pl_to_ps.md
AXIS_PL_TO_PS -- requirements
Module: axis_pl_to_ps

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 128, meaning the width of the ADC-side input word.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, meaning the width of the PS-side output beat; IN_WIDTH SHALL be an integer multiple R = IN_WIDTH/OUT_WIDTH >= 2.
REQ-003 SHALL have parameter FRAME_BEATS, default 1024, meaning the number of output beats per tlast-delimited frame; its legal range is 1 to 2^16.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 clear  input  1  synchronous flush: drops held data and restarts frame counting.
REQ-007 s_axis_tdata  input  IN_WIDTH  ADC-side sample word.
REQ-008 s_axis_tvalid  input  1  input word valid.
REQ-009 s_axis_tready  output  1  block can accept an input word.
REQ-010 m_axis_tdata  output  OUT_WIDTH  PS-side output beat.
REQ-011 m_axis_tvalid  output  1  output beat valid.
REQ-012 m_axis_tready  input  1  PS accepts beat.
REQ-013 m_axis_tlast  output  1  last beat of frame.

Function
REQ-014 SHALL implement a two-state FSM: EMPTY (no word held) and FULL (word held, slice index 0..R-1 pending).
REQ-015 SHALL accept an input word on any rising clk edge with s_axis_tvalid && s_axis_tready, capture it into a hold register, and set slice index to 0.
REQ-016 s_axis_tready SHALL be 1 in EMPTY, 1 in FULL only when slice==R-1 && m_axis_tready, and 0 whenever clear is 1; combinational dependence on m_axis_tready is permitted.
REQ-017 m_axis_tvalid SHALL be 1 exactly when the state is FULL.
REQ-018 m_axis_tdata SHALL equal hold[slice*OUT_WIDTH +: OUT_WIDTH], least-significant slice first.
REQ-019 Latency: a word accepted at edge k SHALL present slice 0 with m_axis_tvalid=1 after edge k.
REQ-020 On each output handshake, slice SHALL increment; on the handshake of slice R-1, the FSM SHALL go to EMPTY unless a new word is accepted on the same edge, in which case it SHALL stay FULL with slice 0 and the new word. This gives 100% throughput with no bubble.
REQ-021 m_axis_tdata and m_axis_tlast SHALL stay stable while m_axis_tvalid && !m_axis_tready.
REQ-022 A beat counter of width clog2(FRAME_BEATS)+1 SHALL count output handshakes.
REQ-023 m_axis_tlast SHALL be 1 when the beat counter equals FRAME_BEATS-1 and m_axis_tvalid is 1.
REQ-024 The beat counter SHALL wrap to 0 on the handshake of the tlast beat.
REQ-025 Frames SHALL span input-word boundaries when FRAME_BEATS is not a multiple of R.
REQ-026 clear=1 SHALL, at the next edge, force EMPTY, slice 0 and beat counter 0, discarding the held word; clear SHALL override any simultaneous input or output handshake, and neither is counted.
REQ-027 When s_axis_tvalid=0 in EMPTY, all outputs SHALL hold and no state SHALL change.

Reset
REQ-028 While rst=1, the block SHALL asynchronously force state EMPTY, slice 0, beat counter 0, m_axis_tvalid 0, m_axis_tlast 0, s_axis_tready 0, and hold register 0.
REQ-029 After rst deasserts, s_axis_tready SHALL be 1 from the first edge, provided clear=0.
REQ-030 A reset asserted mid-word or mid-frame SHALL discard the partial word and partial frame, with no spurious beat after release.

Verification
REQ-031 Single word 0x00000004_00000003_00000002_00000001, m_axis_tready=1 -> beats 0x1, 0x2, 0x3, 0x4 on four consecutive cycles starting the cycle after acceptance, then m_axis_tvalid=0.
REQ-032 Continuous input with m_axis_tready=1 and FRAME_BEATS=8 -> no gaps in m_axis_tvalid, s_axis_tready pulses once every 4 cycles, and m_axis_tlast is high on beats 7, 15, 23.
REQ-033 m_axis_tready toggling randomly at 50% -> the output sequence equals all input words split LSB-first, with no loss or duplication, and data/tlast stable during stalls.
REQ-034 FRAME_BEATS=6 with R=4 -> m_axis_tlast appears on slice 1 of the second word, then on slice 3 of the third word.
REQ-035 clear asserted while FULL at slice 2, with s_axis_tvalid=1 on the same cycle -> the next cycle is EMPTY, m_axis_tvalid=0, the input is not accepted, and the beat counter restarts at 0.
REQ-036 rst pulsed asynchronously between clock edges mid-frame -> outputs go to their reset values immediately, and the first post-reset word yields slice 0 with the beat counter at 0.
